bsg_gateway_mem_arbiter: RTL

Two-requester round-robin arbiter that shares the single testbench memory port (the `bp_mem` lite command/response interface) between the processor's memory path (after `bp_burst_to_lite`) and a second requester such as a host preload or DMA model. It sits in `bsg_gateway_chip` between the requesters and `bp_mem`. It forwards one command at a time, records which requester issued each command, and steers the in-order memory responses back to their originators.

---
 rtl/bsg_chip_pkg.sv | 12 +
 rtl/bsg_fifo_1r1w_small.sv | 60 ++++++
 rtl/bsg_gateway_mem_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/bsg_chip_pkg.sv
// bsg_chip_pkg: chip-level constants shared by the gateway memory arbiter.
//   num_req_gp       number of requesters sharing the bp_mem port
//   src_id_width_gp  width of a requester index stored per outstanding command
//   src_id_t         type of one requester index
package bsg_chip_pkg;

  localparam int num_req_gp      = 2;
  localparam int src_id_width_gp = 1;

  typedef logic [src_id_width_gp-1:0] src_id_t;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small: small one-read/one-write FIFO with a first-word
// fall-through head.
//   blackparrot_clk / blackparrot_reset  clock, async active-low reset
//   v_i, data_i   push request and data (ignored while full_o)
//   full_o        no room for another entry
//   yumi_i        pop the head (ignored while empty_o)
//   data_o        current head entry
//   empty_o       no entries held
module bsg_fifo_1r1w_small #(
  parameter int width_p = 1,
  parameter int els_p   = 4,
  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic               blackparrot_clk,
  input  logic               blackparrot_reset,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               full_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic               empty_o
);

  logic [width_p-1:0]      mem_r [els_p];
  logic [ptr_width_lp-1:0] wr_ptr_r, rd_ptr_r;
  // Disambiguates equal pointers: set means the last change was a push.
  logic                    last_push_r;
  logic                    push, pop;

  assign full_o  = (wr_ptr_r == rd_ptr_r) &  last_push_r;
  assign empty_o = (wr_ptr_r == rd_ptr_r) & ~last_push_r;
  assign push    = v_i    & ~full_o;
  assign pop     = yumi_i & ~empty_o;
  assign data_o  = mem_r[rd_ptr_r];

  function automatic logic [ptr_width_lp-1:0] wrap_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p-1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
    if (!blackparrot_reset) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      last_push_r <= 1'b0;
    end else begin
      if (push) wr_ptr_r <= wrap_inc(wr_ptr_r);
      if (pop)  rd_ptr_r <= wrap_inc(rd_ptr_r);
      if (push != pop) last_push_r <= push;
    end
  end

  // NOTE: the storage array is deliberately not reset; empty_o guards every
  // read, so stale contents are never observed and plain flops/RAM suffice.
  always_ff @(posedge blackparrot_clk) begin
    if (push) mem_r[wr_ptr_r] <= data_i;
  end

endmodule

// File: rtl/bsg_gateway_mem_arbiter.sv
// bsg_gateway_mem_arbiter: shares the single bp_mem lite port between two
// requesters with round-robin priority and routes in-order responses back.
//   blackparrot_clk / blackparrot_reset  clock, async active-low reset
//   cmd_i, cmd_v_i, cmd_ready_and_o      per-requester command channels
//   resp_o, resp_v_o, resp_yumi_i        shared response data, one-hot valid
//   mem_cmd_o, mem_cmd_v_o, mem_cmd_ready_and_i   command to memory
//   mem_resp_i, mem_resp_v_i, mem_resp_yumi_o     response from memory
//   outstanding_o                        commands currently in flight
module bsg_gateway_mem_arbiter
  import bsg_chip_pkg::*;
#(
  parameter int msg_width_p = 640,
  parameter int els_p       = 4,
  localparam int cnt_width_lp = $clog2(els_p+1)
) (
  input  logic                              blackparrot_clk,
  input  logic                              blackparrot_reset,
  input  logic [num_req_gp*msg_width_p-1:0] cmd_i,
  input  logic [num_req_gp-1:0]             cmd_v_i,
  output logic [num_req_gp-1:0]             cmd_ready_and_o,
  output logic [msg_width_p-1:0]            resp_o,
  output logic [num_req_gp-1:0]             resp_v_o,
  input  logic [num_req_gp-1:0]             resp_yumi_i,
  output logic [msg_width_p-1:0]            mem_cmd_o,
  output logic                              mem_cmd_v_o,
  input  logic                              mem_cmd_ready_and_i,
  input  logic [msg_width_p-1:0]            mem_resp_i,
  input  logic                              mem_resp_v_i,
  output logic                              mem_resp_yumi_o,
  output logic [cnt_width_lp-1:0]           outstanding_o
);

  logic                    last_r;
  logic [cnt_width_lp-1:0] count_r;
  logic                    full, empty;
  logic                    push, pop, route_v;
  src_id_t                 winner_id, src;

  // Requester 1 wins only when it is alone or requester 0 had the last grant;
  // with no valid at all the index is don't-care because nothing is pushed.
  assign winner_id = cmd_v_i[1] & (~cmd_v_i[0] | ~last_r);

  // Ready is qualified by the other requester's valid, never by its own, so
  // a requester may raise valid in response to ready without a loop.
  assign cmd_ready_and_o[0] = blackparrot_reset & mem_cmd_ready_and_i & ~full
                            & (~cmd_v_i[1] |  last_r);
  assign cmd_ready_and_o[1] = blackparrot_reset & mem_cmd_ready_and_i & ~full
                            & (~cmd_v_i[0] | ~last_r);

  assign mem_cmd_v_o = blackparrot_reset & (|cmd_v_i) & ~full;
  assign mem_cmd_o   = winner_id ? cmd_i[msg_width_p +: msg_width_p]
                                 : cmd_i[0 +: msg_width_p];
  assign push        = mem_cmd_v_o & mem_cmd_ready_and_i;

  assign resp_o          = mem_resp_i;
  assign route_v         = blackparrot_reset & mem_resp_v_i & ~empty;
  assign resp_v_o[0]     = route_v & ~src;
  assign resp_v_o[1]     = route_v &  src;
  assign mem_resp_yumi_o = |(resp_yumi_i & resp_v_o);
  assign pop             = mem_resp_yumi_o;

  assign outstanding_o = count_r;

  bsg_fifo_1r1w_small #(
    .width_p (src_id_width_gp),
    .els_p   (els_p)
  ) src_fifo (
    .blackparrot_clk   (blackparrot_clk),
    .blackparrot_reset (blackparrot_reset),
    .v_i               (push),
    .data_i            (winner_id),
    .full_o            (full),
    .yumi_i            (pop),
    .data_o            (src),
    .empty_o           (empty)
  );

  // Priority rotates only on an accepted command; last_r resets to 1 so
  // requester 0 wins the first conflict.
  always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
    if (!blackparrot_reset) begin
      last_r  <= 1'b1;
      count_r <= '0;
    end else begin
      if (push) last_r <= winner_id;
      case ({push, pop})
        2'b10:   count_r <= count_r + cnt_width_lp'(1);
        2'b01:   count_r <= count_r - cnt_width_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // A memory response with nothing outstanding means the in-order contract
  // with bp_mem is broken.
  a_resp_while_empty: assert property (@(posedge blackparrot_clk)
    disable iff (!blackparrot_reset) !(mem_resp_v_i && empty));

  // Requesters may only consume a response routed to them.
  a_yumi_without_valid: assert property (@(posedge blackparrot_clk)
    disable iff (!blackparrot_reset) ((resp_yumi_i & ~resp_v_o) == '0));

endmodule
